core_seq: RTL

- Sequencer that drives the 47-bit instruction word of the core for one output tile.
- Loads weights (weight SRAM -> L0 -> PE array), streams activations (activation SRAM -> L0), executes, and drains OFIFO results into psum SRAM.
- Sits between the testbench/top-level host and the core's inst input; observes ofifo_valid only.

---
 rtl/core_seq_pkg.sv | 38 +++
 rtl/core_seq_addr_gen.sv | 43 ++++
 rtl/core_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and instruction-word field map for the core_seq tile sequencer.
// Optional accumulator read-out state is built when CORE_SEQ_ACC_READ_EN is defined.
package core_seq_pkg;

    localparam int unsigned INST_W = 47;

    typedef enum logic [2:0] {
        IDLE,
        W_RD,
        KER,
        X_RD,
        EXEC,
        DRAIN,
        RDOUT,
        DONE
    } state_t;

    // Bit positions inside the 47-bit instruction word (address fields are 11 bits wide).
    localparam int unsigned XMEM_CEN   = 46;
    localparam int unsigned XMEM_WEN   = 45;
    localparam int unsigned XMEM_A_LSB = 34;
    localparam int unsigned ACC_VALID  = 33;
    localparam int unsigned PMEM_CEN   = 32;
    localparam int unsigned PMEM_WEN   = 31;
    localparam int unsigned PMEM_A_LSB = 20;
    localparam int unsigned WMEM_CEN   = 19;
    localparam int unsigned WMEM_WEN   = 18;
    localparam int unsigned WMEM_A_LSB = 7;
    localparam int unsigned OFIFO_RD   = 6;
    localparam int unsigned L0_WR_W    = 5;
    localparam int unsigned EXEC_BIT   = 4;
    localparam int unsigned KER_LOAD   = 3;
    localparam int unsigned L0_WR_X    = 2;

    // All memories deselected and write-disabled, no strobes.
    localparam logic [INST_W-1:0] IDLE_WORD = 47'h6001_800C_0000;

endpackage

// File: rtl/core_seq_addr_gen.sv
// Address stream counter: latches base/terminal count, emits base+k (AW-bit wrap) and k==term.
module core_seq_addr_gen
    import core_seq_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] term,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] count,
    output logic          last
);

    logic [AW-1:0] base_q;
    logic [AW-1:0] term_q;
    logic [AW-1:0] k_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            term_q <= '0;
            k_q    <= '0;
        end else if (load) begin
            base_q <= base;
            term_q <= term;
            k_q    <= '0;
        end else if (clr) begin
            k_q <= '0;
        end else if (en) begin
            k_q <= k_q + AW'(1);
        end
    end

    assign addr  = base_q + k_q;
    assign count = k_q;
    assign last  = (k_q == term_q);

endmodule

// File: rtl/core_seq.sv
// Tile sequencer: weight load, kernel load, activation stream, execute, drain to psum SRAM.
// Define CORE_SEQ_ACC_READ_EN to append a psum read-out (RDOUT) phase before DONE.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned KER_CYC = ROW + COL - 1,
    parameter int unsigned AW      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     w_base,
    input  logic [AW-1:0]     x_base,
    input  logic [AW-1:0]     p_base,
    input  logic [AW-1:0]     n_x,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    state_t state_q, state_d;
    logic [AW-1:0] n_q;
    logic [AW-1:0] cyc_q;
    logic          cyc_en;
    logic          ld, w_en, x_en, p_en, p_clr;
    logic [AW-1:0] w_addr, x_addr, p_addr;
    logic [AW-1:0] w_count, x_count, p_count;
    logic          w_last, x_last, p_last;
    logic [INST_W-1:0] inst_d;

    core_seq_addr_gen #(.AW(AW)) u_w_gen (
        .clk(clk), .reset(reset), .load(ld), .clr(1'b0), .en(w_en),
        .base(w_base), .term(AW'(ROW)),
        .addr(w_addr), .count(w_count), .last(w_last)
    );

    core_seq_addr_gen #(.AW(AW)) u_x_gen (
        .clk(clk), .reset(reset), .load(ld), .clr(1'b0), .en(x_en),
        .base(x_base), .term(n_x),
        .addr(x_addr), .count(x_count), .last(x_last)
    );

    // Terminal count is n_x-1 so the final drain write and the exit happen in the same cycle.
    core_seq_addr_gen #(.AW(AW)) u_p_gen (
        .clk(clk), .reset(reset), .load(ld), .clr(p_clr), .en(p_en),
        .base(p_base), .term(n_x - AW'(1)),
        .addr(p_addr), .count(p_count), .last(p_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ld) n_q <= n_x;
            cyc_q <= cyc_en ? cyc_q + AW'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = IDLE_WORD;
        ld      = 1'b0;
        w_en    = 1'b0;
        x_en    = 1'b0;
        p_en    = 1'b0;
        p_clr   = 1'b0;
        cyc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (n_x != '0)) begin
                    ld      = 1'b1;
                    state_d = W_RD;
                end
            end
            W_RD: begin
                if (!w_last) begin
                    inst_d[WMEM_CEN]             = 1'b0;
                    inst_d[WMEM_A_LSB +: AW]     = w_addr;
                    w_en                         = 1'b1;
                end else begin
                    state_d = KER;
                end
                if (w_count != '0) inst_d[L0_WR_W] = 1'b1;
            end
            KER: begin
                inst_d[KER_LOAD] = 1'b1;
                if (cyc_q == AW'(KER_CYC - 1)) state_d = X_RD;
                else                           cyc_en  = 1'b1;
            end
            X_RD: begin
                if (!x_last) begin
                    inst_d[XMEM_CEN]         = 1'b0;
                    inst_d[XMEM_A_LSB +: AW] = x_addr;
                    x_en                     = 1'b1;
                end else begin
                    state_d = EXEC;
                end
                if (x_count != '0) inst_d[L0_WR_X] = 1'b1;
            end
            EXEC: begin
                inst_d[EXEC_BIT] = 1'b1;
                if (cyc_q == n_q - AW'(1)) state_d = DRAIN;
                else                       cyc_en  = 1'b1;
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    inst_d[OFIFO_RD]         = 1'b1;
                    inst_d[PMEM_CEN]         = 1'b0;
                    inst_d[PMEM_WEN]         = 1'b0;
                    inst_d[PMEM_A_LSB +: AW] = p_addr;
                    p_en                     = 1'b1;
                    if (p_last) begin
`ifdef CORE_SEQ_ACC_READ_EN
                        state_d = RDOUT;
                        p_clr   = 1'b1;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef CORE_SEQ_ACC_READ_EN
            RDOUT: begin
                if (p_count != n_q) begin
                    inst_d[PMEM_CEN]         = 1'b0;
                    inst_d[PMEM_A_LSB +: AW] = p_addr;
                    p_en                     = 1'b1;
                end else begin
                    state_d = DONE;
                end
                if (p_count != '0) inst_d[ACC_VALID] = 1'b1;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered images of the current state's decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst <= IDLE_WORD;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            inst <= inst_d;
            busy <= (state_q != IDLE) && (state_q != DONE);
            done <= (state_q == DONE);
        end
    end

endmodule
